// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output-stage config path:
// output-stage register selects and the write-sequence FSM encoding.
package pwm_pkg;

    localparam logic [1:0] REG_CONFIG    = 2'd0;
    localparam logic [1:0] REG_DATA_LOW  = 2'd1;
    localparam logic [1:0] REG_DATA_HIGH = 2'd2;
    localparam logic [1:0] REG_SEL       = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } state_e;

endpackage

// File: rtl/pwm_cfg_arbiter_rr_arbiter.sv
// Round-robin pick: first valid requester at or after ptr, modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          any_valid
);

    int idx;

    // Scan from the farthest offset back to ptr so the closest valid wins.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (valid[idx]) begin
                grant     = IW'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_cfg_arbiter.sv
// Shares the PWM output-stage config bus among several requesters;
// each grant becomes a setup cycle followed by a single sel strobe.
module pwm_cfg_arbiter
    import pwm_pkg::*;
#(
    parameter int REQUESTERS    = 4,
    parameter int CHANNELS      = 2,
    parameter int CH_W          = 1,
    parameter int PWM_REG_WIDTH = 32
) (
    input  logic                              clk_peri,
    input  logic                              reset_n,
    input  logic [REQUESTERS-1:0]             req_valid,
    output logic [REQUESTERS-1:0]             req_ready,
    input  logic [REQUESTERS-1:0]             req_bcast,
    input  logic [REQUESTERS*CH_W-1:0]        req_ch,
    input  logic [REQUESTERS*2-1:0]           req_adr,
    input  logic [REQUESTERS*PWM_REG_WIDTH-1:0] req_data,
    output logic [CHANNELS-1:0]               pwm_sel,
    output logic [1:0]                        pwm_adr,
    output logic [PWM_REG_WIDTH-1:0]          pwm_data,
    output logic                              busy,
    output logic                              err_pulse,
    output logic [15:0]                       wr_count
);

    localparam int RW = $clog2(REQUESTERS);

    state_e                   state_q, state_d;
    logic [RW-1:0]            rr_q, rr_d;
    logic [1:0]               adr_q, adr_d;
    logic [PWM_REG_WIDTH-1:0] data_q, data_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic                     bcast_q, bcast_d;
    logic                     bad_q, bad_d;
    logic [CHANNELS-1:0]      sel_q, sel_d;
    logic                     busy_q, busy_d;
    logic                     err_q, err_d;
    logic [15:0]              cnt_q, cnt_d;

    logic [RW-1:0]            grant;
    logic                     any_valid;
    logic [CH_W-1:0]          w_ch;
    logic [1:0]               w_adr;
    logic [PWM_REG_WIDTH-1:0] w_data;
    logic                     w_bcast;
    logic                     w_bad;

    rr_arbiter #(
        .N  (REQUESTERS),
        .IW (RW)
    ) u_rr (
        .valid     (req_valid),
        .ptr       (rr_q),
        .grant     (grant),
        .any_valid (any_valid)
    );

    always_comb begin
        w_ch    = req_ch[int'(grant)*CH_W +: CH_W];
        w_adr   = req_adr[int'(grant)*2 +: 2];
        w_data  = req_data[int'(grant)*PWM_REG_WIDTH +: PWM_REG_WIDTH];
        w_bcast = req_bcast[grant];
        w_bad   = !w_bcast && (int'(w_ch) >= CHANNELS);
    end

    assign req_ready = (state_q == IDLE && any_valid) ?
                       (REQUESTERS'(1) << grant) : '0;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        adr_d   = adr_q;
        data_d  = data_q;
        ch_d    = ch_q;
        bcast_d = bcast_q;
        bad_d   = bad_q;
        sel_d   = '0;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = SETUP;
                    rr_d    = (grant == RW'(REQUESTERS - 1)) ? '0 : grant + 1'b1;
                    adr_d   = w_adr;
                    data_d  = w_data;
                    ch_d    = w_ch;
                    bcast_d = w_bcast;
                    bad_d   = w_bad;
                    busy_d  = 1'b1;
                    err_d   = w_bad;
                end
            end
            SETUP: begin
                state_d = STROBE;
                busy_d  = 1'b1;
                // A dropped request still walks through STROBE, just silently.
                if (!bad_q) begin
                    sel_d = bcast_q ? '1 : (CHANNELS'(1) << ch_q);
                end
                if (sel_d != '0 && cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STROBE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_peri or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            adr_q   <= REG_CONFIG;
            data_q  <= '0;
            ch_q    <= '0;
            bcast_q <= 1'b0;
            bad_q   <= 1'b0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            bcast_q <= bcast_d;
            bad_q   <= bad_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pwm_sel   = sel_q;
    assign pwm_adr   = adr_q;
    assign pwm_data  = data_q;
    assign busy      = busy_q;
    assign err_pulse = err_q;
    assign wr_count  = cnt_q;

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Scoreboard bench: stimulus queues expected grants and strobes,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_pwm_cfg_arbiter;

    localparam int REQ = 4;
    localparam int CH  = 2;
    localparam int CHW = 1;
    localparam int W   = 32;

    logic clk_peri = 1'b0;
    logic reset_n  = 1'b0;

    logic [REQ-1:0]     req_valid = '0;
    logic [REQ-1:0]     req_ready;
    logic [REQ-1:0]     req_bcast = '0;
    logic [REQ*CHW-1:0] req_ch    = '0;
    logic [REQ*2-1:0]   req_adr   = '0;
    logic [REQ*W-1:0]   req_data  = '0;
    logic [CH-1:0]      pwm_sel;
    logic [1:0]         pwm_adr;
    logic [W-1:0]       pwm_data;
    logic               busy;
    logic               err_pulse;
    logic [15:0]        wr_count;

    logic [3:0]   b_valid = '0;
    logic [3:0]   b_ready;
    logic [3:0]   b_bcast = '0;
    logic [7:0]   b_ch    = '0;
    logic [7:0]   b_adr   = '0;
    logic [127:0] b_data  = '0;
    logic [2:0]   b_sel;
    logic [1:0]   b_adr_o;
    logic [31:0]  b_data_o;
    logic         b_busy;
    logic         b_err;
    logic [15:0]  b_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;
    int r2_grants;

    int                    gq[$];
    logic [CH+2+W-1:0]     sq[$];

    pwm_cfg_arbiter #(
        .REQUESTERS(REQ), .CHANNELS(CH), .CH_W(CHW), .PWM_REG_WIDTH(W)
    ) dut (
        .clk_peri(clk_peri), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_bcast(req_bcast), .req_ch(req_ch),
        .req_adr(req_adr), .req_data(req_data),
        .pwm_sel(pwm_sel), .pwm_adr(pwm_adr), .pwm_data(pwm_data),
        .busy(busy), .err_pulse(err_pulse), .wr_count(wr_count)
    );

    pwm_cfg_arbiter #(
        .REQUESTERS(4), .CHANNELS(3), .CH_W(2), .PWM_REG_WIDTH(32)
    ) dut3 (
        .clk_peri(clk_peri), .reset_n(reset_n),
        .req_valid(b_valid), .req_ready(b_ready),
        .req_bcast(b_bcast), .req_ch(b_ch),
        .req_adr(b_adr), .req_data(b_data),
        .pwm_sel(b_sel), .pwm_adr(b_adr_o), .pwm_data(b_data_o),
        .busy(b_busy), .err_pulse(b_err), .wr_count(b_cnt)
    );

    always #5 clk_peri = ~clk_peri;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_strobe(input logic bc, input logic [CHW-1:0] ch,
                               input logic [1:0] adr, input logic [W-1:0] data);
        logic [CH-1:0] s;
        s = bc ? 2'b11 : (2'b01 << ch);
        sq.push_back({s, adr, data});
        exp_cnt++;
    endtask

    // Raise a request after the next posedge, hold until granted, then drop.
    task automatic issue(input int r, input logic bc, input logic [CHW-1:0] ch,
                         input logic [1:0] adr, input logic [W-1:0] data);
        logic got;
        got = 1'b0;
        @(posedge clk_peri);
        #1;
        req_bcast[r]          = bc;
        req_ch[r*CHW +: CHW]  = ch;
        req_adr[r*2 +: 2]     = adr;
        req_data[r*W +: W]    = data;
        req_valid[r]          = 1'b1;
        for (int n = 0; n <= 3*REQ && !got; n++) begin
            @(negedge clk_peri);
            got = req_ready[r];
        end
        chk($sformatf("wait_r%0d", r), 64'(got), 64'd1);
        @(posedge clk_peri);
        #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic run3(input logic [1:0] ch, input logic [2:0] esel,
                        input logic eerr, input logic [15:0] ecnt);
        @(posedge clk_peri);
        #1;
        b_ch[1:0]    = ch;
        b_adr[1:0]   = 2'd2;
        b_data[31:0] = 32'hDEAD_BEEF;
        b_valid[0]   = 1'b1;
        @(negedge clk_peri);
        chk("t5_ready", 64'(b_ready), 64'h1);
        @(posedge clk_peri);
        #1;
        b_valid[0] = 1'b0;
        @(negedge clk_peri);
        chk("t5_setup_err", 64'(b_err), 64'(eerr));
        chk("t5_setup_sel", 64'(b_sel), 64'h0);
        @(negedge clk_peri);
        chk("t5_strobe_sel", 64'(b_sel), 64'(esel));
        chk("t5_strobe_err", 64'(b_err), 64'h0);
        @(negedge clk_peri);
        chk("t5_idle_busy", 64'(b_busy), 64'h0);
        chk("t5_count", 64'(b_cnt), 64'(ecnt));
    endtask

    always @(negedge clk_peri) begin
        if (reset_n) begin
            if (req_ready != '0) begin
                if (gq.size() == 0) chk("grant_unexpected", 64'(req_ready), 64'h0);
                else chk("grant", 64'(req_ready), 64'(1) << gq.pop_front());
            end
            if (pwm_sel != '0) begin
                if (sq.size() == 0) chk("strobe_unexpected", 64'(pwm_sel), 64'h0);
                else chk("strobe", 64'({pwm_sel, pwm_adr, pwm_data}), 64'(sq.pop_front()));
            end
            if (err_pulse) chk("err_unexpected", 64'(err_pulse), 64'h0);
        end
    end

    initial begin
        repeat (2) @(posedge clk_peri);
        @(negedge clk_peri);
        chk("rst_sel", 64'(pwm_sel), 0);
        chk("rst_adr", 64'(pwm_adr), 0);
        chk("rst_data", 64'(pwm_data), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_err", 64'(err_pulse), 0);
        chk("rst_count", 64'(wr_count), 0);
        chk("rst_ready", 64'(req_ready), 0);
        reset_n = 1'b1;

        // single request, cycle-exact
        gq.push_back(0);
        push_strobe(1'b0, 1'b1, 2'd2, 32'h0001_2345);
        issue(0, 1'b0, 1'b1, 2'd2, 32'h0001_2345);
        @(negedge clk_peri);
        chk("t1_setup_sel", 64'(pwm_sel), 64'h0);
        chk("t1_setup_busy", 64'(busy), 64'h1);
        chk("t1_setup_adr", 64'(pwm_adr), 64'h2);
        chk("t1_setup_data", 64'(pwm_data), 64'h0001_2345);
        @(negedge clk_peri);
        chk("t1_strobe_sel", 64'(pwm_sel), 64'h2);
        @(negedge clk_peri);
        chk("t1_idle_busy", 64'(busy), 64'h0);
        chk("t1_count", 64'(wr_count), 64'(exp_cnt));

        // all four from reset
        @(negedge clk_peri);
        reset_n = 1'b0;
        @(negedge clk_peri);
        reset_n = 1'b1;
        exp_cnt = 0;
        for (int r = 0; r < REQ; r++) begin
            gq.push_back(r);
            push_strobe(1'b0, 1'(r), 2'(r), 32'hA000_0000 + 32'(r));
        end
        fork
            issue(0, 1'b0, 1'b0, 2'd0, 32'hA000_0000);
            issue(1, 1'b0, 1'b1, 2'd1, 32'hA000_0001);
            issue(2, 1'b0, 1'b0, 2'd2, 32'hA000_0002);
            issue(3, 1'b0, 1'b1, 2'd3, 32'hA000_0003);
        join
        repeat (3) @(negedge clk_peri);
        chk("t2_count", 64'(wr_count), 64'(exp_cnt));

        // pointer back at 0: r0 beats r3, then r3 (wrap)
        gq.push_back(0);
        push_strobe(1'b0, 1'b0, 2'd1, 32'h0000_00C0);
        gq.push_back(3);
        push_strobe(1'b0, 1'b1, 2'd2, 32'h0000_00C3);
        fork
            issue(3, 1'b0, 1'b1, 2'd2, 32'h0000_00C3);
            issue(0, 1'b0, 1'b0, 2'd1, 32'h0000_00C0);
        join
        repeat (3) @(negedge clk_peri);

        // r2 continuous, r1 raised once: 2,1,2,2
        gq.push_back(2);
        push_strobe(1'b0, 1'b0, 2'd3, 32'h2222_2222);
        gq.push_back(1);
        push_strobe(1'b0, 1'b1, 2'd1, 32'h1111_1111);
        for (int k = 0; k < 2; k++) begin
            gq.push_back(2);
            push_strobe(1'b0, 1'b0, 2'd3, 32'h2222_2222);
        end
        @(posedge clk_peri);
        #1;
        req_bcast[2]     = 1'b0;
        req_ch[2]        = 1'b0;
        req_adr[5:4]     = 2'd3;
        req_data[95:64]  = 32'h2222_2222;
        req_valid[2]     = 1'b1;
        fork
            issue(1, 1'b0, 1'b1, 2'd1, 32'h1111_1111);
            begin
                r2_grants = 0;
                for (int n = 0; n < 40 && r2_grants < 3; n++) begin
                    @(negedge clk_peri);
                    if (req_ready[2]) r2_grants++;
                end
                chk("t3_r2_grants", 64'(r2_grants), 64'd3);
                @(posedge clk_peri);
                #1;
                req_valid[2] = 1'b0;
            end
        join
        repeat (4) @(negedge clk_peri);
        chk("t3_count", 64'(wr_count), 64'(exp_cnt));

        // broadcast
        gq.push_back(0);
        push_strobe(1'b1, 1'b0, 2'd1, 32'h0);
        issue(0, 1'b1, 1'b0, 2'd1, 32'h0);
        repeat (3) @(negedge clk_peri);
        chk("t4_count", 64'(wr_count), 64'(exp_cnt));

        // out-of-range channel on a 3-channel instance, then a legal one
        run3(2'd3, 3'b000, 1'b1, 16'd0);
        run3(2'd2, 3'b100, 1'b0, 16'd1);

        // reset during SETUP
        gq.push_back(0);
        issue(0, 1'b0, 1'b1, 2'd3, 32'h6666_6666);
        chk("t6_busy_pre", 64'(busy), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_sel", 64'(pwm_sel), 0);
        chk("t6_adr", 64'(pwm_adr), 0);
        chk("t6_data", 64'(pwm_data), 0);
        chk("t6_busy", 64'(busy), 0);
        chk("t6_count", 64'(wr_count), 0);
        exp_cnt = 0;
        @(posedge clk_peri);
        @(negedge clk_peri);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_peri);
        chk("t6_no_strobe", 64'(wr_count), 0);
        gq.push_back(0);
        push_strobe(1'b0, 1'b0, 2'd2, 32'h0BAD_F00D);
        issue(0, 1'b0, 1'b0, 2'd2, 32'h0BAD_F00D);
        repeat (3) @(negedge clk_peri);
        chk("t6_after", 64'(wr_count), 64'(exp_cnt));

        repeat (2) @(negedge clk_peri);
        chk("grants_drained", 64'(gq.size()), 0);
        chk("strobes_drained", 64'(sq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
